// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the 5-stage RV32 pipeline.
// Generates stall/flush/bubble strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. Handles load-use hazards, branch/jump redirects with a configurable
// IF/ID flush tail, and freezes the pipe during multi-cycle data-memory accesses
// with a timeout abort.
//
// Parameters:
//   FLUSH_CYCLES  extra IF/ID flush cycles after a redirect (0..15)
//   MEM_TIMEOUT   maximum MEM_WAIT cycles before abort (1..255)
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   id_rs1/id_rs2, id_uses_rs1/2   decode source indices and use flags
//   ex_rd, ex_MemRead, ex_redirect EX-stage destination, load flag, taken redirect
//   mem_MemRead/MemWrite, mem_done MEM-stage request and completion
//   pc_stall ... mem_wb_bubble     per-stage strobes (combinational, forced 0 in reset)
//   mem_err                        sticky memory-timeout flag
//   ctrl_state                     0=RUN, 1=MEM_WAIT, 2=FLUSH
// Optional build macro PIPE_CTRL_PERF_EN adds saturating performance counters
// perf_stall_cycles, perf_flush_cycles and perf_load_use.
module pipeline_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_MemRead,
  input  logic       ex_redirect,
  input  logic       mem_MemRead,
  input  logic       mem_MemWrite,
  input  logic       mem_done,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       mem_wb_bubble,
  output logic       mem_err,
  output logic [1:0] ctrl_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_cycles,
  output logic [15:0] perf_load_use
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TCNT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic                mem_err_q, mem_err_d;

  logic mem_req, freeze, load_use;
  logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c;
  logic id_ex_flush_c, ex_mem_stall_c, mem_wb_bubble_c, load_use_evt_c;

  // Hazard terms
  assign mem_req  = mem_MemRead | mem_MemWrite;
  assign freeze   = mem_req & ~mem_done;
  assign load_use = ex_MemRead & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  // Next-state and strobe generation; priority freeze > redirect > flush tail > load-use
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    tcnt_d          = tcnt_q;
    mem_err_d       = mem_err_q;
    pc_stall_c      = 1'b0;
    if_id_stall_c   = 1'b0;
    if_id_flush_c   = 1'b0;
    id_ex_stall_c   = 1'b0;
    id_ex_flush_c   = 1'b0;
    ex_mem_stall_c  = 1'b0;
    mem_wb_bubble_c = 1'b0;
    load_use_evt_c  = 1'b0;

    if ((state_q == ST_MEM_WAIT) && freeze && (tcnt_q >= TCNT_W'(MEM_TIMEOUT))) begin
      // Timeout abort: let the pipe move but kill the MEM/WB write
      mem_wb_bubble_c = 1'b1;
      mem_err_d       = 1'b1;
      state_d         = ST_RUN;
      cnt_d           = '0;
      tcnt_d          = '0;
    end else if (freeze) begin
      pc_stall_c      = 1'b1;
      if_id_stall_c   = 1'b1;
      id_ex_stall_c   = 1'b1;
      ex_mem_stall_c  = 1'b1;
      mem_wb_bubble_c = 1'b1;
      if (state_q != ST_MEM_WAIT) begin
        // cnt is preserved so an interrupted flush tail resumes later
        state_d = ST_MEM_WAIT;
        tcnt_d  = TCNT_W'(1);
      end else if (tcnt_q != '1) begin
        tcnt_d = tcnt_q + TCNT_W'(1);
      end
    end else if (ex_redirect) begin
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      tcnt_d        = '0;
      if (FLUSH_CYCLES != 0) begin
        state_d = ST_FLUSH;
        cnt_d   = CNT_W'(FLUSH_CYCLES);
      end else begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end else if (cnt_q != '0) begin
      if_id_flush_c = 1'b1;
      tcnt_d        = '0;
      if (state_q == ST_MEM_WAIT) begin
        // Leaving a freeze: resume the saved tail without consuming a count
        state_d = ST_FLUSH;
      end else if (cnt_q == CNT_W'(1)) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      state_d = ST_RUN;
      tcnt_d  = '0;
      if (load_use) begin
        pc_stall_c     = 1'b1;
        if_id_stall_c  = 1'b1;
        id_ex_flush_c  = 1'b1;
        load_use_evt_c = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Strobes are forced low while reset is held
  assign pc_stall      = pc_stall_c      & rst_n;
  assign if_id_stall   = if_id_stall_c   & rst_n;
  assign if_id_flush   = if_id_flush_c   & rst_n;
  assign id_ex_stall   = id_ex_stall_c   & rst_n;
  assign id_ex_flush   = id_ex_flush_c   & rst_n;
  assign ex_mem_stall  = ex_mem_stall_c  & rst_n;
  assign mem_wb_bubble = mem_wb_bubble_c & rst_n;
  assign mem_err       = mem_err_q;
  assign ctrl_state    = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;
  logic [15:0] perf_lu_q, perf_lu_d;

  // Saturating event counters
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    perf_lu_d    = perf_lu_q;
    if (pc_stall_c && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
    if (if_id_flush_c && (perf_flush_q != '1)) perf_flush_d = perf_flush_q + 32'd1;
    if (load_use_evt_c && (perf_lu_q != '1)) perf_lu_d = perf_lu_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_lu_q    <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
      perf_lu_q    <= perf_lu_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_cycles = perf_flush_q;
  assign perf_load_use     = perf_lu_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: a stimulus process drives each cycle and
// pushes the expected strobes from a behavioural model; a monitor pops and compares.
module tb_pipeline_ctrl;

  localparam int FC = 2;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic       ex_MemRead = 1'b0, ex_redirect = 1'b0;
  logic       mem_MemRead = 1'b0, mem_MemWrite = 1'b0, mem_done = 1'b0;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, mem_wb_bubble, mem_err;
  logic [1:0] ctrl_state;

  pipeline_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_redirect(ex_redirect),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_done(mem_done),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble),
    .mem_err(mem_err), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  // Observation bundle: {pc,ifid_st,ifid_fl,idex_st,idex_fl,exmem_st,bubble,err,state}
  typedef struct packed {
    logic       pc;
    logic       ifid_st;
    logic       ifid_fl;
    logic       idex_st;
    logic       idex_fl;
    logic       exmem_st;
    logic       bub;
    logic       err;
    logic [1:0] st;
  } obs_t;

  typedef struct {
    obs_t exp;
    int   cyc;
  } item_t;

  item_t expq[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;

  // Reference model: memory-wait flag/length, remaining flush cycles, sticky error
  bit m_wait = 1'b0;
  int m_wlen = 0;
  int m_flush = 0;
  bit m_err = 1'b0;

  function automatic obs_t observe();
    obs_t o;
    o = '{pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
          ex_mem_stall, mem_wb_bubble, mem_err, ctrl_state};
    return o;
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 1'b0; m_wlen = 0; m_flush = 0; m_err = 1'b0;
  endtask

  // One cycle of stimulus; expected response computed from the behavioural rules
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input bit u1, input bit u2,
                       input logic [4:0] rd, input bit exmr, input bit redir,
                       input bit mr, input bit mw, input bit done);
    obs_t  e;
    item_t it;
    bit    frz, lu, was_wait;
    @(negedge clk);
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_MemRead = exmr; ex_redirect = redir;
    mem_MemRead = mr; mem_MemWrite = mw; mem_done = done;
    frz = (mr || mw) && !done;
    lu  = exmr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    e = '0;
    e.err = m_err;
    e.st  = m_wait ? 2'd1 : (m_flush > 0 ? 2'd2 : 2'd0);
    if (frz && m_wait && m_wlen >= TO) begin
      e.bub = 1'b1;
      m_err = 1'b1; m_wait = 1'b0; m_flush = 0;
    end else if (frz) begin
      e.pc = 1; e.ifid_st = 1; e.idex_st = 1; e.exmem_st = 1; e.bub = 1;
      m_wlen = m_wait ? m_wlen + 1 : 1;
      m_wait = 1'b1;
    end else begin
      was_wait = m_wait;
      m_wait = 1'b0;
      if (redir) begin
        e.ifid_fl = 1; e.idex_fl = 1;
        m_flush = FC;
      end else if (m_flush > 0) begin
        e.ifid_fl = 1;
        if (!was_wait) m_flush--;
      end else if (lu) begin
        e.pc = 1; e.ifid_st = 1; e.idex_fl = 1;
      end
    end
    it.exp = e;
    it.cyc = cyc;
    expq.push_back(it);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every presented cycle against the scoreboard head
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && expq.size() > 0) begin
        it = expq.pop_front();
        check($sformatf("cycle%0d", it.cyc), observe(), it.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("reset_outputs", observe(), 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // Load-use on rs1, then the rd=0 and rs2 variants
    drive(5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
    idle(1);
    drive(5, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    drive(3, 7, 0, 1, 7, 1, 0, 0, 0, 0);
    drive(3, 7, 0, 0, 7, 1, 0, 0, 0, 0);
    idle(1);

    // Redirect pulse and flush tail
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    idle(3);

    // Multi-cycle load, then zero-wait store
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // Redirect held across a 2-cycle freeze
    repeat (2) drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
    idle(3);

    // Freeze interrupting a flush tail
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(3);

    // Timeout abort and sticky error
    repeat (TO + 1) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(3);

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6));
    end

    // Async reset asserted mid-cycle while in MEM_WAIT
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #3;
    mon_en = 1'b0;
    expq.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", observe(), 10'b0);
    mem_MemRead = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    idle(3);

    @(negedge clk);
    #4;
    check("scoreboard_drained", 10'(expq.size()), 10'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32 pipeline. It generates per-stage stall, flush and bubble strobes.
- Detects load-use hazards against the decode stage register indices and handles flushes on taken branches and jumps.
- Freezes the whole pipeline while a multi-cycle data-memory access completes, with a timeout guard.
- Sits beside the pipeline registers. Consumes the decode rs indices and the EX/MEM control bits; drives the enables of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
FLUSH_CYCLES, 1, extra cycles IF/ID is flushed after a redirect (covers instruction-memory latency); 0..15
MEM_TIMEOUT, 255, maximum cycles in MEM_WAIT before abort; 1..255

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
id_rs1  in  5  decode rs1 index
id_rs2  in  5  decode rs2 index
id_uses_rs1  in  1  decode instruction reads rs1
id_uses_rs2  in  1  decode instruction reads rs2
ex_rd  in  5  EX-stage destination
ex_MemRead  in  1  EX-stage instruction is a load
ex_redirect  in  1  EX resolved taken branch / JAL / JALR
mem_MemRead  in  1  MEM-stage load
mem_MemWrite  in  1  MEM-stage store
mem_done  in  1  data memory completes the access this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  zero IF/ID (NOP)
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  load bubble into ID/EX
ex_mem_stall  out  1  hold EX/MEM
mem_wb_bubble  out  1  MEM/WB gets RegWrite=0
mem_err  out  1  sticky: memory timeout occurred
ctrl_state  out  2  0=RUN, 1=MEM_WAIT, 2=FLUSH

Behaviour:
- Reset (async, rst_n low):
  - state=RUN; flush counter=0; timeout counter=0; mem_err=0.
  - All outputs 0, including while reset is asserted mid-operation. Deassertion returns to RUN on the next edge.
- Definitions:
  - mem_req = mem_MemRead | mem_MemWrite
  - freeze = mem_req & ~mem_done, valid in RUN, FLUSH or MEM_WAIT
  - load_use = ex_MemRead & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))
- Priority (combinational outputs): freeze > redirect > flush counter > load_use.
- Freeze:
  - pc_stall, if_id_stall, id_ex_stall and ex_mem_stall = 1; mem_wb_bubble = 1.
  - All flush outputs are 0.
  - Zero-wait access (mem_req & mem_done in the same cycle) produces no stall.
- Redirect (no freeze):
  - if_id_flush = 1 and id_ex_flush = 1 for that cycle. PC loads the target (pc_stall = 0).
  - If FLUSH_CYCLES > 0, go to FLUSH with cnt = FLUSH_CYCLES.
  - A redirect that coincides with freeze is held by EX and acted on in the first unfrozen cycle.
- FLUSH state:
  - if_id_flush = 1 each cycle. cnt decrements when not frozen; at cnt == 1 the state returns to RUN.
  - A new redirect in FLUSH reloads cnt.
  - Freeze in FLUSH holds cnt and moves the state to MEM_WAIT. The saved cnt is resumed afterwards: return to FLUSH if cnt != 0.
- Load-use (RUN, no freeze, no redirect):
  - pc_stall = 1, if_id_stall = 1, id_ex_flush = 1 for exactly one cycle.
  - Next cycle ex_MemRead is clear, so no repeat. ex_rd = 0 never stalls.
- MEM_WAIT:
  - Entered on the edge after freeze first asserts. tcnt counts cycles in MEM_WAIT.
  - Exit when mem_done: the outputs are unfrozen in that same cycle, and the state leaves on the next edge.
  - If tcnt reaches MEM_TIMEOUT with no mem_done: set mem_err (sticky until reset), force mem_wb_bubble = 1 and all stalls = 0 for one cycle (abort), then go to RUN. The MEM stage must drop the request.
- Counters saturate; no wrap.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: adds outputs perf_stall_cycles[31:0] (cycles with pc_stall = 1), perf_flush_cycles[31:0] (cycles with if_id_flush = 1) and perf_load_use[15:0] (load-use events). All reset to 0 and saturate.
- Undefined: these ports and their registers are absent; behaviour is otherwise identical.

Test Plan:
- Load-use: ex_MemRead = 1, ex_rd = 5, id_rs1 = 5, id_uses_rs1 = 1 -> one cycle of pc_stall = if_id_stall = id_ex_flush = 1, then all 0. The same stimulus with ex_rd = 0 -> no stall.
- Redirect, FLUSH_CYCLES = 2: ex_redirect pulse at cycle N -> if_id_flush = 1 at N, N+1 and N+2; id_ex_flush = 1 at N only; ctrl_state = 2 at N+1 and N+2, then 0.
- Memory wait: mem_MemRead = 1, mem_done low for 3 cycles then high -> all stalls and mem_wb_bubble = 1 for 3 cycles; ctrl_state = 1 from the 2nd cycle; unfrozen in the mem_done cycle. A zero-wait access -> no stall.
- Freeze plus redirect: ex_redirect = 1 held during a 2-cycle freeze -> no flush while frozen; the flush fires in the first unfrozen cycle.
- Timeout, MEM_TIMEOUT = 4: mem_req held with mem_done = 0 -> mem_err rises after 4 MEM_WAIT cycles; a 1-cycle abort; return to RUN; mem_err stays 1 until rst_n pulses low.
- Async reset: assert rst_n low in MEM_WAIT mid-clock -> outputs go to 0 immediately; ctrl_state = 0 after release.
